// File: rtl/sdram_handoff_if.sv
// Handshake bundle between the SDRAM handoff sequencer and its neighbours:
// Nios request/grant, camera capture controls and the arbiter ownership lines.
interface sdram_handoff_if #(
  parameter int FRAME_CNT_W = 8
) ();
  logic                   nios_req;
  logic                   nios_grant;
  logic                   cam_vsync;
  logic                   cam_wr_busy;
  logic                   cam_pause;
  logic                   RequestNiosControl;
  logic                   NiosHasControl;
  logic                   CamHasControl;
  logic                   handoff_err;
  logic [FRAME_CNT_W-1:0] frames_since_grant;

  modport master (
    input  nios_req, cam_vsync, cam_wr_busy, NiosHasControl, CamHasControl,
    output nios_grant, cam_pause, RequestNiosControl, handoff_err, frames_since_grant
  );

  modport slave (
    output nios_req, cam_vsync, cam_wr_busy, NiosHasControl, CamHasControl,
    input  nios_grant, cam_pause, RequestNiosControl, handoff_err, frames_since_grant
  );
endinterface

// File: rtl/sdram_handoff_ctrl.sv
// Sequences SDRAM ownership from the camera writer to the Nios at frame
// boundaries, after the write path drains, with a handoff stall watchdog.
module sdram_handoff_ctrl #(
  parameter int MIN_CAM_FRAMES = 1,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int FRAME_CNT_W    = 8
) (
  input  logic                clk,
  input  logic                Reset,
  sdram_handoff_if.master     bus
);

  typedef enum logic [2:0] {
    CAM_RUN, WAIT_FRAME, WAIT_IDLE, REQ_NIOS, NIOS_RUN, RELEASE
  } state_t;

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0]        TO_MAX  = TO_W'(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0]        TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [FRAME_CNT_W-1:0] MIN_FR  = FRAME_CNT_W'(MIN_CAM_FRAMES);

  state_t                 state;
  logic                   vsync_q;
  logic [TO_W-1:0]        to_cnt;
  logic [FRAME_CNT_W-1:0] frames;
  logic                   grant_q;
  logic                   req_q;
  logic                   pause_q;
  logic                   err_q;
  logic                   vs_rise;

  assign vs_rise = bus.cam_vsync & ~vsync_q;

  assign bus.nios_grant         = grant_q;
  assign bus.RequestNiosControl = req_q;
  assign bus.cam_pause          = pause_q;
  assign bus.handoff_err        = err_q;
  assign bus.frames_since_grant = frames;

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent logic.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state   <= RELEASE;
      vsync_q <= 1'b0;
      to_cnt  <= '0;
      frames  <= '0;
      grant_q <= 1'b0;
      req_q   <= 1'b0;
      pause_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      vsync_q <= bus.cam_vsync;

      unique case (state)
        CAM_RUN: begin
          if (vs_rise && frames != '1) frames <= frames + 1'b1;
          // Compare uses the registered count, so a same-cycle vsync only
          // counts toward the threshold on the following cycle.
          if (bus.nios_req && frames >= MIN_FR) state <= WAIT_FRAME;
        end

        WAIT_FRAME: begin
          if (vs_rise && frames != '1) frames <= frames + 1'b1;
          if (vs_rise) begin
            pause_q <= 1'b1;
            state   <= WAIT_IDLE;
          end else if (!bus.nios_req) begin
            state <= CAM_RUN;
          end
        end

        WAIT_IDLE: begin
          if (!bus.cam_wr_busy) begin
            req_q  <= 1'b1;
            to_cnt <= '0;
            state  <= REQ_NIOS;
          end
        end

        REQ_NIOS: begin
          if (bus.NiosHasControl) begin
            grant_q <= 1'b1;
            to_cnt  <= '0;
            state   <= NIOS_RUN;
          end else begin
            if (to_cnt != TO_MAX) to_cnt <= to_cnt + 1'b1;
            if (to_cnt >= TO_LAST) err_q <= 1'b1;
          end
        end

        NIOS_RUN: begin
          // Losing ownership without asking is a handoff fault in its own right.
          if (!bus.NiosHasControl || !bus.nios_req) begin
            if (!bus.NiosHasControl) err_q <= 1'b1;
            grant_q <= 1'b0;
            req_q   <= 1'b0;
            to_cnt  <= '0;
            state   <= RELEASE;
          end
        end

        RELEASE: begin
          if (bus.CamHasControl) begin
            pause_q <= 1'b0;
            frames  <= '0;
            to_cnt  <= '0;
            state   <= CAM_RUN;
          end else begin
            if (to_cnt != TO_MAX) to_cnt <= to_cnt + 1'b1;
            if (to_cnt >= TO_LAST) err_q <= 1'b1;
          end
        end

        default: state <= RELEASE;
      endcase
    end
  end

endmodule

// File: doc/sdram_handoff_ctrl.md
Name: sdram_handoff_ctrl

Overview:
- Upstream sequencer for the SDRAM arbiter. It turns a level request from the Nios into a clean ownership handoff.
- Drives the arbiter's RequestNiosControl only at camera frame boundaries, after the camera write path has drained.
- Tells the Nios when it owns the SDRAM, and tells the camera capture path when to pause.
- Guarantees a minimum number of camera frames between Nios grants, and flags arbiter handoffs that stall.

Parameters:
- MIN_CAM_FRAMES, 1: complete camera frames that must be written after a release before the next Nios grant is allowed. 0 means no minimum.
- TIMEOUT_CYCLES, 1024: clk cycles allowed in REQ_NIOS or RELEASE before handoff_err sets.
- FRAME_CNT_W, 8: width of frames_since_grant.

Ports:
- clk  in  1  system clock; all logic runs on its rising edge.
- Reset  in  1  reset, asynchronous, active-high.
- nios_req  in  1  Nios wants the SDRAM. Level signal, held for the whole access window.
- nios_grant  out  1  Nios may issue SDRAM commands.
- cam_vsync  in  1  camera frame sync, already synchronous to clk. A rising edge marks a frame start.
- cam_wr_busy  in  1  camera writer has a burst in flight or its FIFO is not empty.
- cam_pause  out  1  camera capture must hold off starting new frame writes.
- RequestNiosControl  out  1  to the arbiter.
- NiosHasControl  in  1  from the arbiter.
- CamHasControl  in  1  from the arbiter.
- handoff_err  out  1  sticky: a handoff exceeded TIMEOUT_CYCLES.
- frames_since_grant  out  FRAME_CNT_W  camera frames started since the last release. Saturates at all-ones.

Behaviour:
- All outputs are registered.
- Reset values:
  - state = RELEASE
  - RequestNiosControl = 0
  - nios_grant = 0
  - cam_pause = 1
  - handoff_err = 0
  - frames_since_grant = 0
  - timeout counter = 0
  - vsync_q = 0
- Reset asserted mid-operation forces these values immediately, including a drop of nios_grant within the same cycle (asynchronous). After reset the arbiter leaves Nios ownership on its own; the block waits in RELEASE for CamHasControl.
- vs_rise = cam_vsync & ~vsync_q, with vsync_q registered every cycle.
- States: CAM_RUN, WAIT_FRAME, WAIT_IDLE, REQ_NIOS, NIOS_RUN, RELEASE.
- CAM_RUN:
  - Outputs: cam_pause = 0, RequestNiosControl = 0, nios_grant = 0.
  - Each vs_rise increments frames_since_grant, saturating.
  - If nios_req = 1 and frames_since_grant >= MIN_CAM_FRAMES, go to WAIT_FRAME.
- WAIT_FRAME:
  - If nios_req drops, return to CAM_RUN.
  - On vs_rise: cam_pause = 1 from the next cycle, go to WAIT_IDLE. The frame counter still increments on this edge.
  - From here on the handoff is committed, regardless of nios_req.
- WAIT_IDLE:
  - cam_pause = 1.
  - When cam_wr_busy = 0, go to REQ_NIOS with RequestNiosControl = 1 on the same edge.
- REQ_NIOS:
  - RequestNiosControl = 1; the timeout counter increments each cycle.
  - On NiosHasControl = 1, go to NIOS_RUN; nios_grant = 1 on that edge and the counter clears.
  - If nios_req has dropped by then, still enter NIOS_RUN; it exits on the next cycle.
- NIOS_RUN:
  - nios_grant = 1, RequestNiosControl = 1, cam_pause = 1.
  - If nios_req = 0, go to RELEASE; nios_grant and RequestNiosControl drop on that edge.
  - If NiosHasControl drops unexpectedly, set handoff_err and go to RELEASE.
- RELEASE:
  - RequestNiosControl = 0, nios_grant = 0, cam_pause = 1; the timeout counter increments.
  - On CamHasControl = 1, go to CAM_RUN; clear frames_since_grant and the counter; cam_pause = 0 on that edge.
- Timeout:
  - If the counter reaches TIMEOUT_CYCLES in REQ_NIOS or RELEASE, set handoff_err.
  - The state keeps waiting and the counter holds at TIMEOUT_CYCLES.
  - handoff_err clears only on Reset.
- Simultaneous events:
  - vs_rise in the same cycle that CamHasControl exits RELEASE: the counter clears (clear wins).
  - nios_req rise together with vs_rise in CAM_RUN: the increment applies first, then the threshold compare uses the new value on the following cycle.
- With MIN_CAM_FRAMES = 0, the CAM_RUN→WAIT_FRAME move happens on the first cycle nios_req = 1.
- Grant latency after nios_req, best case = wait for vsync + drain + arbiter handoff + 1 cycle. nios_grant is never 1 unless NiosHasControl was 1 on the previous edge.

Test Plan:
1. Reset pulse mid-NIOS_RUN, then CamHasControl rises 4 cycles later → nios_grant = 0 immediately, cam_pause = 1, state RELEASE; CAM_RUN on the CamHasControl edge; cam_pause = 0; frames_since_grant = 0.
2. MIN_CAM_FRAMES = 1, frames_since_grant = 1, nios_req = 1, vs_rise at cycle 5, cam_wr_busy low at cycle 9, NiosHasControl at cycle 13 → cam_pause = 1 at cycle 6; RequestNiosControl = 1 at cycle 10; nios_grant = 1 at cycle 14.
3. nios_req falls in NIOS_RUN, CamHasControl after 4 cycles → nios_grant and RequestNiosControl = 0 next edge; cam_pause = 0 and frames_since_grant = 0 after CamHasControl.
4. After a release, nios_req held high with MIN_CAM_FRAMES = 2 → no WAIT_FRAME until two vs_rise edges counted; handoff begins at the third vs_rise.
5. TIMEOUT_CYCLES = 16, NiosHasControl held 0 in REQ_NIOS → handoff_err = 1 after 16 cycles, RequestNiosControl stays 1; NiosHasControl later rises → grant still given, err stays 1.
6. nios_req pulses high for 3 cycles in WAIT_FRAME with no vsync → returns to CAM_RUN, cam_pause never asserted, RequestNiosControl stays 0.
